// File: rtl/rename_serialize_ctrl_pkg.sv
// Shared types for the rename-stage serializer.
//   serialize_kind_e  : latched class of a serialized op (CSR, FENCE, FENCE_I)
//   serialize_phase_e : controller phase
//   decode_kind()     : maps the raw 2-bit lane kind onto serialize_kind_e
package rename_serialize_ctrl_pkg;

    typedef enum logic [1:0] {
        SER_CSR     = 2'd0,
        SER_FENCE   = 2'd1,
        SER_FENCE_I = 2'd2
    } serialize_kind_e;

    typedef enum logic [1:0] {
        PH_NORMAL     = 2'd0,
        PH_WAIT_OWN   = 2'd1,
        PH_WAIT_FLUSH = 2'd2
    } serialize_phase_e;

    // Reserved encoding 3 behaves as FENCE (the safe, fully draining choice).
    function automatic serialize_kind_e decode_kind(input logic [1:0] raw);
        case (raw)
            2'd0:    return SER_CSR;
            2'd2:    return SER_FENCE_I;
            default: return SER_FENCE;
        endcase
    endfunction

endpackage

// File: rtl/rename_serialize_ctrl_if.sv
// Rename group / serializer interface.
//   master : upstream side (drives group, stall/clear, queue status, flush done)
//   slave  : serializer side (drives laneEnable, holdGroup, icFlushReq, timeout)
interface rename_serialize_ctrl_if #(
    parameter int unsigned WIDTH = 2
);
    logic                 stall;
    logic                 clear;
    logic [WIDTH-1:0]     valid;
    logic [WIDTH-1:0]     serialized;
    logic [2*WIDTH-1:0]   serKind;
    logic                 activeListEmpty;
    logic                 storeQueueEmpty;
    logic                 icFlushDone;
    logic [WIDTH-1:0]     laneEnable;
    logic                 holdGroup;
    logic                 icFlushReq;
    logic                 timeout;

    modport master (
        output stall, clear, valid, serialized, serKind,
               activeListEmpty, storeQueueEmpty, icFlushDone,
        input  laneEnable, holdGroup, icFlushReq, timeout
    );

    modport slave (
        input  stall, clear, valid, serialized, serKind,
               activeListEmpty, storeQueueEmpty, icFlushDone,
        output laneEnable, holdGroup, icFlushReq, timeout
    );
endinterface

// File: rtl/rename_serialize_ctrl_lane_select.sv
// Priority encoder for the serializer: finds the oldest still-pending
// serialized lane and the pending lanes older than it.
//   valid, serialized, done_mask : lane status in
//   pend       : valid lanes not yet renamed in this group
//   sel_idx    : index of oldest pending serialized lane (k)
//   sel_onehot : one-hot of k (zero when no_ser)
//   no_ser     : no pending serialized lane
//   older_mask : pending lanes below k (all pending lanes when no_ser)
module rename_serialize_ctrl_lane_select #(
    parameter int unsigned WIDTH = 2,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] valid,
    input  logic [WIDTH-1:0] serialized,
    input  logic [WIDTH-1:0] done_mask,
    output logic [WIDTH-1:0] pend,
    output logic [IDX_W-1:0] sel_idx,
    output logic [WIDTH-1:0] sel_onehot,
    output logic             no_ser,
    output logic [WIDTH-1:0] older_mask
);

    assign pend = valid & ~done_mask;

    // Scan from the top so the lowest match wins.
    always_comb begin
        sel_idx    = '0;
        no_ser     = 1'b1;
        sel_onehot = '0;
        older_mask = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pend[i] && serialized[i]) begin
                sel_idx = IDX_W'(i);
                no_ser  = 1'b0;
            end
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!no_ser && (IDX_W'(i) == sel_idx)) begin
                sel_onehot[i] = 1'b1;
            end
            if (no_ser || (IDX_W'(i) < sel_idx)) begin
                older_mask[i] = pend[i];
            end
        end
    end

endmodule

// File: rtl/rename_serialize_ctrl.sv
// Rename-stage serializer. Lets older lanes rename first, renames a
// serialized op alone once the machine has drained, holds younger lanes
// until it commits, issues an I-cache flush for FENCE_I, and flags a stuck
// serialization through a watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : group/status inputs; laneEnable/holdGroup/icFlushReq are
//                combinational from state and inputs, timeout is registered
module rename_serialize_ctrl
    import rename_serialize_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rename_serialize_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    serialize_phase_e phase_q, phase_d;
    serialize_kind_e  kind_q, kind_d, cur_kind;
    logic [WIDTH-1:0] done_q, done_d;
    logic             flush_seen_q, flush_seen_d;
    logic [WD_W-1:0]  wd_q, wd_next;
    logic             timeout_q;

    logic [WIDTH-1:0] pend, sel_onehot, older_mask, lane_en;
    logic [IDX_W-1:0] sel_idx;
    logic             no_ser, hold, flush_req, drained, both_empty, wd_inc;
    logic [1:0]       cur_raw;

    rename_serialize_ctrl_lane_select #(.WIDTH(WIDTH)) u_sel (
        .valid      (bus.valid),
        .serialized (bus.serialized),
        .done_mask  (done_q),
        .pend       (pend),
        .sel_idx    (sel_idx),
        .sel_onehot (sel_onehot),
        .no_ser     (no_ser),
        .older_mask (older_mask)
    );

    // Raw kind of lane k, picked through the one-hot to keep indices constant.
    always_comb begin
        cur_raw = 2'b00;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sel_onehot[i]) begin
                cur_raw = bus.serKind[2*i +: 2];
            end
        end
    end

    assign cur_kind   = decode_kind(cur_raw);
    assign both_empty = bus.activeListEmpty && bus.storeQueueEmpty;
    // CSR ops only need the active list empty; fences also wait on stores.
    assign drained    = bus.activeListEmpty && ((cur_kind == SER_CSR) || bus.storeQueueEmpty);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_NORMAL;
            kind_q       <= SER_CSR;
            done_q       <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            kind_q       <= kind_d;
            done_q       <= done_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Next-state and per-lane gating.
    always_comb begin
        phase_d   = phase_q;
        kind_d    = kind_q;
        done_d    = done_q;
        lane_en   = '0;
        hold      = 1'b0;
        flush_req = 1'b0;
        case (phase_q)
            PH_NORMAL: begin
                if (no_ser) begin
                    lane_en = pend;
                    if (!bus.stall) done_d = '0;
                end else if (|older_mask) begin
                    lane_en = older_mask;
                    hold    = 1'b1;
                    if (!bus.stall) done_d = done_q | older_mask;
                end else begin
                    hold = 1'b1;
                    if (drained) begin
                        lane_en = sel_onehot;
                        if (!bus.stall) begin
                            done_d  = done_q | sel_onehot;
                            kind_d  = cur_kind;
                            phase_d = PH_WAIT_OWN;
                        end
                    end
                end
            end
            PH_WAIT_OWN: begin
                hold = 1'b1;
                if (!bus.stall && both_empty) begin
                    if (kind_q == SER_FENCE_I) begin
                        flush_req = 1'b1;
                        phase_d   = PH_WAIT_FLUSH;
                    end else begin
                        phase_d = PH_NORMAL;
                    end
                end
            end
            PH_WAIT_FLUSH: begin
                hold = 1'b1;
                if (!bus.stall && (bus.icFlushDone || flush_seen_q)) phase_d = PH_NORMAL;
            end
            default: phase_d = PH_NORMAL;
        endcase
        // An issued flush must still complete, so clear never leaves WAIT_FLUSH.
        if (bus.clear) begin
            lane_en   = '0;
            flush_req = 1'b0;
            done_d    = '0;
            phase_d   = (phase_q == PH_WAIT_FLUSH) ? PH_WAIT_FLUSH : PH_NORMAL;
        end
    end

    // A flush-done pulse arriving while stalled/cleared in WAIT_FLUSH is kept
    // until the phase can actually advance, otherwise the pulse would be lost.
    assign flush_seen_d = (phase_q == PH_WAIT_FLUSH) && (phase_d == PH_WAIT_FLUSH)
                          && (flush_seen_q || bus.icFlushDone);

    // Watchdog: counts cycles spent serializing or fully blocked.
    assign wd_inc  = (phase_q != PH_NORMAL) || (hold && (lane_en == '0));
    assign wd_next = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (bus.clear) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (wd_inc) begin
            wd_q <= wd_next;
            if (wd_next == WD_MAX) timeout_q <= 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    assign bus.laneEnable = lane_en;
    assign bus.holdGroup  = hold;
    assign bus.icFlushReq = flush_req;
    assign bus.timeout    = timeout_q;

`ifndef SYNTHESIS
    a_en_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (lane_en & ~bus.valid) == '0);
    a_one_ser: assert property (@(posedge clk) disable iff (!rst_n)
        $countones(lane_en & bus.serialized) <= 1);
    a_flush_req: assert property (@(posedge clk) disable iff (!rst_n)
        flush_req |-> (phase_q == PH_WAIT_OWN && phase_d == PH_WAIT_FLUSH));
`endif

endmodule
